// File: rtl/serial_to_parallel_rx_if.sv
// ----------------------------------------------------------------------------
// serial_to_parallel_rx_if
//
// Purpose:
//   Bundles the serial input and the recovered-byte outputs of the
//   serial_to_parallel_rx byte aligner. Clock and reset are not part of the
//   bundle; they stay plain ports on the module.
//
// Signals:
//   data_in    1  serial bit, MSB of each byte first
//   data_out   8  recovered byte (updates at every aligned byte boundary)
//   valid_out  1  one-cycle pulse, data_out holds a payload byte
//   active     1  alignment achieved, link up
//
// Modports:
//   master  the side that produces the serial stream and consumes the bytes
//   slave   the receiver itself (serial_to_parallel_rx)
// ----------------------------------------------------------------------------
interface serial_to_parallel_rx_if;

    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active
    );

endinterface : serial_to_parallel_rx_if

// File: rtl/serial_to_parallel_rx.sv
// ----------------------------------------------------------------------------
// serial_to_parallel_rx
//
// Purpose:
//   Receive-side byte aligner for an MSB-first serial bit stream. It searches
//   the stream bit by bit for the COMMA symbol, then confirms alignment by
//   requiring BC_COUNT consecutive COMMAs on byte boundaries. Once aligned the
//   link is declared active (permanently, until reset) and one byte is
//   presented every 8 bit-times. Payload bytes are flagged with a one-cycle
//   valid_out pulse; COMMA and IDLE filler bytes are shown on data_out but
//   never flagged valid.
//
// Parameters:
//   COMMA     alignment symbol (default 8'hBC)
//   IDLE      idle filler symbol (default 8'h7C)
//   BC_COUNT  consecutive aligned COMMAs needed to go active (1..15)
//
// Ports:
//   dclk     in   serial bit clock, every register updates on its rising edge
//   reset_L  in   synchronous, active-low reset
//   rx       slave modport of serial_to_parallel_rx_if
//              rx.data_in    in   serial bit
//              rx.data_out   out  recovered byte
//              rx.valid_out  out  payload-byte strobe
//              rx.active     out  link up
// ----------------------------------------------------------------------------
module serial_to_parallel_rx #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter logic [7:0]  IDLE     = 8'h7C,
    parameter int unsigned BC_COUNT = 4
) (
    input  logic                    dclk,
    input  logic                    reset_L,
    serial_to_parallel_rx_if.slave  rx
);

    // Target count held in the same width as the counter it is compared to.
    localparam logic [3:0] BC_TARGET = BC_COUNT[3:0];
    // A single COMMA is enough: HUNT goes straight to ACTIVE.
    localparam logic       BC_IS_ONE = (BC_COUNT == 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_ACTIVE  = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_e     state_r;
    logic [7:0] sr_r;
    logic [2:0] bit_cnt_r;
    logic [3:0] bc_cnt_r;
    logic [7:0] data_out_r;
    logic       valid_r;
    logic       active_r;

    // Next-state values produced by the combinational process
    state_e     state_nxt_s;
    logic [2:0] bit_cnt_nxt_s;
    logic [3:0] bc_cnt_nxt_s;
    logic [7:0] data_out_nxt_s;
    logic       valid_nxt_s;
    logic       active_nxt_s;

    // ------------------------------------------------------------------------
    // Decode of the byte completed by the bit arriving this cycle
    // ------------------------------------------------------------------------
    logic [7:0] window_s;
    logic       is_comma_s;
    logic       is_idle_s;
    logic       boundary_s;
    logic [3:0] bc_inc_s;

    // The window includes the live input bit so a match is acted on at the
    // very edge that samples the last bit of the symbol.
    assign window_s   = {sr_r[6:0], rx.data_in};
    assign is_comma_s = (window_s == COMMA);
    assign is_idle_s  = (window_s == IDLE);
    // bit_cnt is 7 while the last bit of an aligned byte is on data_in.
    assign boundary_s = (bit_cnt_r == 3'd7);
    assign bc_inc_s   = bc_cnt_r + 4'd1;

    // ------------------------------------------------------------------------
    // Outputs come straight from registers
    // ------------------------------------------------------------------------
    assign rx.data_out  = data_out_r;
    assign rx.valid_out = valid_r;
    assign rx.active    = active_r;

    // Next-state and next-output logic for the alignment FSM
    always_comb begin
        state_nxt_s    = state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        bc_cnt_nxt_s   = bc_cnt_r;
        data_out_nxt_s = data_out_r;
        valid_nxt_s    = 1'b0;
        active_nxt_s   = active_r;

        case (state_r)
            ST_HUNT: begin
                active_nxt_s = 1'b0;
                // Bit-granular search: any cycle may complete a COMMA.
                if (is_comma_s) begin
                    bc_cnt_nxt_s  = 4'd1;
                    bit_cnt_nxt_s = 3'd0;
                    if (BC_IS_ONE) begin
                        state_nxt_s  = ST_ACTIVE;
                        active_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s  = ST_LOCKING;
                        active_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_HUNT;
                end
            end

            ST_LOCKING: begin
                active_nxt_s  = 1'b0;
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                if (boundary_s) begin
                    if (is_comma_s) begin
                        bc_cnt_nxt_s = bc_inc_s;
                        if (bc_inc_s == BC_TARGET) begin
                            state_nxt_s  = ST_ACTIVE;
                            active_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s  = ST_LOCKING;
                        end
                    end else begin
                        // Alignment broken; the breaking byte is not
                        // re-examined as a COMMA candidate this cycle.
                        bc_cnt_nxt_s = 4'd0;
                        state_nxt_s  = ST_HUNT;
                    end
                end else begin
                    state_nxt_s = ST_LOCKING;
                end
            end

            ST_ACTIVE: begin
                active_nxt_s  = 1'b1;
                bit_cnt_nxt_s = bit_cnt_r + 3'd1;
                // Every aligned byte is shown; only payload is flagged.
                // Alignment is never rechecked here, COMMAs are just dropped.
                if (boundary_s) begin
                    data_out_nxt_s = window_s;
                    valid_nxt_s    = !is_idle_s && !is_comma_s;
                end else begin
                    valid_nxt_s    = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: fall back to a clean search state.
                state_nxt_s   = ST_HUNT;
                bit_cnt_nxt_s = 3'd0;
                bc_cnt_nxt_s  = 4'd0;
                active_nxt_s  = 1'b0;
                valid_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, shift register and output registers with synchronous reset
    always_ff @(posedge dclk) begin
        if (!reset_L) begin
            state_r    <= ST_HUNT;
            sr_r       <= 8'h00;
            bit_cnt_r  <= 3'd0;
            bc_cnt_r   <= 4'd0;
            data_out_r <= 8'h00;
            valid_r    <= 1'b0;
            active_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sr_r       <= window_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            bc_cnt_r   <= bc_cnt_nxt_s;
            data_out_r <= data_out_nxt_s;
            valid_r    <= valid_nxt_s;
            active_r   <= active_nxt_s;
        end
    end

endmodule : serial_to_parallel_rx

// File: tb/tb_serial_to_parallel_rx.sv
// ----------------------------------------------------------------------------
// tb_serial_to_parallel_rx
//
// Directed bench for serial_to_parallel_rx. Two instances share one serial
// stream and reset: dut_a uses BC_COUNT = 4, dut_b uses BC_COUNT = 1.
// Bits are driven after the rising edge and outputs are sampled 1 time unit
// after the edge that consumed the bit.
// ----------------------------------------------------------------------------
module tb_serial_to_parallel_rx;

    logic dclk;
    logic reset_L;
    logic din;

    int tests;
    int fails;
    int va;   // valid_out pulses seen on dut_a
    int vb;   // valid_out pulses seen on dut_b

    logic [7:0] com;
    logic [7:0] byte_v;

    serial_to_parallel_rx_if ifa ();
    serial_to_parallel_rx_if ifb ();

    assign ifa.data_in = din;
    assign ifb.data_in = din;

    serial_to_parallel_rx #(
        .COMMA    (8'hBC),
        .IDLE     (8'h7C),
        .BC_COUNT (4)
    ) dut_a (
        .dclk    (dclk),
        .reset_L (reset_L),
        .rx      (ifa)
    );

    serial_to_parallel_rx #(
        .COMMA    (8'hBC),
        .IDLE     (8'h7C),
        .BC_COUNT (1)
    ) dut_b (
        .dclk    (dclk),
        .reset_L (reset_L),
        .rx      (ifb)
    );

    // Bit clock
    initial begin
        dclk = 1'b0;
        forever #5 dclk = ~dclk;
    end

    // Run-time bound
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        @(posedge dclk);
        #1;
        if (ifa.valid_out === 1'b1) va++;
        if (ifb.valid_out === 1'b1) vb++;
    endtask

    // Sends the top n bits of b, MSB first.
    task automatic send_partial(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_partial(b, 8);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        din     = 1'b0;
        @(posedge dclk);
        @(posedge dclk);
        #1;
        check("rst_a_data",   ifa.data_out,         8'h00);
        check("rst_a_valid",  {7'd0, ifa.valid_out}, 8'h00);
        check("rst_a_active", {7'd0, ifa.active},    8'h00);
        check("rst_b_active", {7'd0, ifb.active},    8'h00);
        reset_L = 1'b1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        va      = 0;
        vb      = 0;
        reset_L = 1'b0;
        din     = 1'b0;
        com     = 8'hBC;

        // ---------------- Aligned lock ----------------
        do_reset();
        va = 0;
        send_byte(com);
        send_byte(com);
        send_byte(com);
        send_partial(com, 7);
        check("aligned_active_bit31", {7'd0, ifa.active}, 8'h00);
        send_bit(com[0]);
        check("aligned_active_bit32", {7'd0, ifa.active}, 8'h01);
        check("aligned_no_valid", va[7:0], 8'h00);

        // ---------------- Misaligned lock ----------------
        do_reset();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_byte(com);
        send_byte(com);
        send_byte(com);
        send_partial(com, 7);
        check("misal_active_before", {7'd0, ifa.active}, 8'h00);
        send_bit(com[0]);
        check("misal_active_after", {7'd0, ifa.active}, 8'h01);
        va = 0;
        byte_v = 8'hA5;
        send_partial(byte_v, 7);
        check("misal_no_early_valid", va[7:0], 8'h00);
        send_bit(byte_v[0]);
        check("misal_valid", {7'd0, ifa.valid_out}, 8'h01);
        check("misal_data",  ifa.data_out, 8'hA5);
        check("misal_one_pulse", va[7:0], 8'h01);
        send_bit(1'b0);
        check("misal_valid_drop", {7'd0, ifa.valid_out}, 8'h00);

        // ---------------- Broken lock ----------------
        do_reset();
        send_byte(com);
        send_byte(com);
        send_byte(com);
        check("broken_active_3com", {7'd0, ifa.active}, 8'h00);
        send_byte(8'h55);
        check("broken_active_55", {7'd0, ifa.active}, 8'h00);
        send_byte(com);
        send_byte(com);
        send_byte(com);
        check("broken_active_relock3", {7'd0, ifa.active}, 8'h00);
        send_byte(com);
        check("broken_active_relock4", {7'd0, ifa.active}, 8'h01);

        // ---------------- Filtering in ACTIVE ----------------
        va = 0;
        send_byte(8'h12);
        check("filt_12_valid", {7'd0, ifa.valid_out}, 8'h01);
        check("filt_12_data",  ifa.data_out, 8'h12);
        send_byte(8'h7C);
        check("filt_7c_valid", {7'd0, ifa.valid_out}, 8'h00);
        check("filt_7c_data",  ifa.data_out, 8'h7C);
        send_byte(com);
        check("filt_bc_valid", {7'd0, ifa.valid_out}, 8'h00);
        check("filt_bc_data",  ifa.data_out, 8'hBC);
        check("filt_bc_active", {7'd0, ifa.active}, 8'h01);
        send_byte(8'hFF);
        check("filt_ff_valid", {7'd0, ifa.valid_out}, 8'h01);
        check("filt_ff_data",  ifa.data_out, 8'hFF);
        check("filt_pulse_count", va[7:0], 8'h02);

        // ---------------- Reset mid-byte ----------------
        byte_v = 8'hC3;
        send_bit(byte_v[7]);
        check("mid_valid_one_cycle", {7'd0, ifa.valid_out}, 8'h00);
        send_bit(byte_v[6]);
        send_bit(byte_v[5]);
        send_bit(byte_v[4]);
        check("mid_data_hold", ifa.data_out, 8'hFF);
        reset_L = 1'b0;
        din     = byte_v[3];
        @(posedge dclk);
        #1;
        check("mid_rst_data",   ifa.data_out,          8'h00);
        check("mid_rst_valid",  {7'd0, ifa.valid_out}, 8'h00);
        check("mid_rst_active", {7'd0, ifa.active},    8'h00);
        reset_L = 1'b1;
        va = 0;
        send_byte(com);
        send_byte(com);
        send_byte(com);
        check("mid_relock_3com", {7'd0, ifa.active}, 8'h00);
        send_byte(com);
        check("mid_relock_4com", {7'd0, ifa.active}, 8'h01);
        check("mid_relock_no_valid", va[7:0], 8'h00);

        // ---------------- BC_COUNT = 1 ----------------
        do_reset();
        vb = 0;
        send_partial(com, 7);
        check("bc1_active_before", {7'd0, ifb.active}, 8'h00);
        send_bit(com[0]);
        check("bc1_active_after", {7'd0, ifb.active}, 8'h01);
        check("bc1_com_no_valid", {7'd0, ifb.valid_out}, 8'h00);
        check("bc1_a_not_active", {7'd0, ifa.active}, 8'h00);
        send_byte(8'h3C);
        check("bc1_valid", {7'd0, ifb.valid_out}, 8'h01);
        check("bc1_data",  ifb.data_out, 8'h3C);
        check("bc1_pulse_count", vb[7:0], 8'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_serial_to_parallel_rx
